// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: major opcodes, the canonical NOP and the
// instruction-fetch state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_FULL
    } fetch_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that parks a fetch response while
// decode is stalled.
module fetch_skid_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;

    // Clear (redirect) outranks a same-cycle load so a stale response never parks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            instr_q <= in_instr;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign valid     = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, registered
// IF/ID bundle with a one-entry skid buffer and execute-stage redirects.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [6:0]      if_opcode
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [31:0]     if_instr_q, if_instr_d;

    logic            slot_free;
    logic            skid_load, skid_drain, skid_clear;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;

    assign slot_free = !if_valid_q || !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    state_d = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = (redirect || slot_free) ? S_REQ : S_FULL;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_FULL: begin
                if (redirect || !stall) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // rst_n gating keeps the request low while memory is also held in reset.
    always_comb begin
        imem_req  = rst_n && (state_q == S_REQ);
        imem_addr = pc_q;
    end

    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (redirect) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            skid_clear = 1'b1;
        end else begin
            if (slot_free) begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt) begin
                        pend_pc_d = pc_q;
                        pc_d      = pc_q + XLEN'(4);
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pend_pc_q;
                            if_instr_d = imem_rdata;
                        end else begin
                            skid_load = 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        if_valid_d = skid_valid;
                        if_pc_d    = skid_pc;
                        if_instr_d = skid_instr;
                        skid_drain = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
        end else begin
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    fetch_skid_buffer #(
        .XLEN (XLEN)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .in_pc     (pend_pc_q),
        .in_instr  (imem_rdata),
        .valid     (skid_valid),
        .out_pc    (skid_pc),
        .out_instr (skid_instr)
    );

    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = opcode_of(if_instr_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural imem with programmable latency
// and a scoreboard of expected IF/ID bundles.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_q[$];
    logic        pending = 1'b0;
    logic        stale   = 1'b0;
    logic [31:0] pend_addr = '0;
    int          cnt = 0;
    int          lat = 1;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        logic [6:0] ops [4];
        ops[0] = 7'b0010011;
        ops[1] = 7'b0110011;
        ops[2] = 7'b0000011;
        ops[3] = 7'b0100011;
        if (a == 32'h0) return 32'h0050_0093;
        return {a[26:2] ^ 25'h0A5_A5A5, ops[a[3:2]]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called just after a falling edge with this cycle's inputs set.
    task automatic tick();
        logic        acc, fire, rd, stl, pv;
        logic [31:0] ppc, pin;
        logic [63:0] e;
        acc  = imem_req && imem_gnt;
        fire = imem_rvalid;
        rd   = redirect;
        stl  = stall;
        pv   = if_valid;
        ppc  = if_pc;
        pin  = if_instr;
        if (fire) begin
            if (!stale && !rd) exp_q.push_back({pend_addr, imem_f(pend_addr)});
            pending = 1'b0;
        end
        if (acc) begin
            pending   = 1'b1;
            cnt       = lat;
            pend_addr = imem_addr;
            stale     = rd;
        end else if (rd && pending) begin
            stale = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (pending && cnt > 0) cnt--;
        imem_rvalid = pending && (cnt == 0);
        imem_rdata  = imem_rvalid ? imem_f(pend_addr) : 32'hDEAD_BEEF;
        if (pv && stl && !rd) begin
            check("hold_valid", {31'd0, if_valid}, 32'd1);
            check("hold_pc", if_pc, ppc);
            check("hold_instr", if_instr, pin);
        end else if (if_valid) begin
            check("bundle_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bundle_pc", if_pc, e[63:32]);
                check("bundle_instr", if_instr, e[31:0]);
                check("bundle_opcode", {25'd0, if_opcode}, {25'd0, e[6:0]});
            end
        end
    endtask

    task automatic wait_req(input int max);
        int n;
        n = 0;
        while (!imem_req && n < max) begin
            tick();
            n++;
        end
        check("wait_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic wait_bundle(input int max);
        int n;
        n = 1;
        tick();
        while (!if_valid && n < max) begin
            tick();
            n++;
        end
        check("wait_bundle", {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_opcode", {25'd0, if_opcode}, 32'h13);
        check("rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_req", {31'd0, imem_req}, 32'd1);

        // Back-to-back fetch, latency 1
        tick();
        check("wait_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_valid", {31'd0, if_valid}, 32'd1);
        check("first_opcode", {25'd0, if_opcode}, 32'h13);
        check("next_addr", imem_addr, 32'd4);
        tick();
        tick();
        check("second_pc", if_pc, 32'd4);

        // Stall while the response arrives: skid buffer parks it
        stall = 1'b1;
        tick();
        tick();
        check("skid_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("skid_still_no_req", {31'd0, imem_req}, 32'd0);
        check("stall_pc_held", if_pc, 32'd4);
        stall = 1'b0;
        tick();
        check("skid_drain_pc", if_pc, 32'd8);
        check("skid_drain_req", {31'd0, imem_req}, 32'd1);

        // Redirect while waiting; stale response arrives two cycles later
        lat = 3;
        wait_req(8);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check("drop_req", {31'd0, imem_req}, 32'd0);
        check("drop_addr", imem_addr, 32'h0000_0100);
        check("drop_valid", {31'd0, if_valid}, 32'd0);
        tick();
        tick();
        check("after_drop_req", {31'd0, imem_req}, 32'd1);
        check("after_drop_addr", imem_addr, 32'h0000_0100);

        // Redirect with simultaneous rvalid and stall
        lat = 1;
        wait_req(8);
        tick();
        tick();
        check("redir_pre_pc", if_pc, 32'h0000_0100);
        stall = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("rrs_valid", {31'd0, if_valid}, 32'd0);
        check("rrs_req", {31'd0, imem_req}, 32'd1);
        check("rrs_addr", imem_addr, 32'h0000_0200);
        stall = 1'b0;
        wait_bundle(8);
        check("rrs_bundle_pc", if_pc, 32'h0000_0200);

        // Redirect in S_REQ with a same-cycle grant
        lat = 2;
        wait_req(8);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        check("rg_req", {31'd0, imem_req}, 32'd0);
        check("rg_addr", imem_addr, 32'h0000_0300);
        tick();
        tick();
        check("rg_after_req", {31'd0, imem_req}, 32'd1);
        check("rg_after_addr", imem_addr, 32'h0000_0300);
        wait_bundle(8);
        check("rg_bundle_pc", if_pc, 32'h0000_0300);

        // PC wrap at the top of the address space
        lat = 1;
        wait_req(8);
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        check("wrap_req", {31'd0, imem_req}, 32'd1);
        check("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr", imem_addr, 32'd0);
        tick();
        check("wrap_bundle_pc", if_pc, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of S_WAIT
        lat = 3;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, if_valid}, 32'd0);
        check("arst_pc", if_pc, 32'd0);
        check("arst_instr", if_instr, 32'h0000_0013);
        check("arst_addr", imem_addr, 32'd0);
        pending     = 1'b0;
        stale       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel_req", {31'd0, imem_req}, 32'd1);
        lat = 1;
        wait_bundle(8);
        check("arst_bundle_pc", if_pc, 32'd0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
